// File: rtl/frame_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// frame_buffer_sequencer
//
// Frame-level controller placed in front of a 1-bit double-buffered frame
// buffer. Each frame it clears the back buffer, lets the renderer write into
// it, then waits for renderer completion plus the next vsync before issuing
// a one-cycle buffer swap.
//
// Optional feature macro: FRAME_BUFFER_SEQUENCER_STATS_EN
//   defined   -> missed_vsync counts vsync pulses not used for a swap
//                (saturating, cleared only by rst_n)
//   undefined -> missed_vsync is tied to 0, no counter is built
//
// Ports
//   clk           system clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   ce            clock enable; 0 freezes all state
//   vsync         one-cycle pulse at start of vertical blanking
//   r_wr_en       renderer pixel write strobe
//   r_wr_addr     renderer pixel address
//   r_wr_data     renderer pixel value
//   r_done        one-cycle pulse: renderer finished frame
//   render_start  one-cycle pulse: renderer may begin frame
//   fb_wr_en      frame buffer (back buffer) write enable
//   fb_wr_addr    frame buffer write address
//   fb_wr_data    frame buffer write data
//   fb_swap       one-cycle pulse: toggle displayed buffer
//   frame_cnt     number of swaps issued, wraps
//   missed_vsync  vsync pulses not used for a swap
// ---------------------------------------------------------------------------
module frame_buffer_sequencer #(
  parameter int   ADDR_W      = 19,
  parameter int   PIXELS      = 307200,
  parameter logic CLEAR_VALUE = 1'b0,
  parameter int   CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              vsync,
  input  logic              r_wr_en,
  input  logic [ADDR_W-1:0] r_wr_addr,
  input  logic              r_wr_data,
  input  logic              r_done,
  output logic              render_start,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic              fb_wr_data,
  output logic              fb_swap,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  missed_vsync
);

  // ST_START is the single cycle after the last clear write; it issues
  // render_start so that the pulse follows the final clear write.
  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_RENDER = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  // One extra bit so the range check also works when PIXELS == 2**ADDR_W.
  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W + 1)'(PIXELS);

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
  logic              render_start_reg, render_start_next;
  logic              fb_wr_en_reg, fb_wr_en_next;
  logic [ADDR_W-1:0] fb_wr_addr_reg, fb_wr_addr_next;
  logic              fb_wr_data_reg, fb_wr_data_next;
  logic              fb_swap_reg, fb_swap_next;
  logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;

  logic              addr_in_range;

  assign addr_in_range = ({1'b0, r_wr_addr} < PIX_LIMIT);

  always_comb begin
    state_next        = state_reg;
    clr_addr_next     = clr_addr_reg;
    render_start_next = 1'b0;
    fb_wr_en_next     = 1'b0;
    fb_wr_addr_next   = fb_wr_addr_reg;
    fb_wr_data_next   = fb_wr_data_reg;
    fb_swap_next      = 1'b0;
    frame_cnt_next    = frame_cnt_reg;
    if (ce) begin
      case (state_reg)
        ST_CLEAR: begin
          fb_wr_en_next   = 1'b1;
          fb_wr_addr_next = clr_addr_reg;
          fb_wr_data_next = CLEAR_VALUE;
          if (clr_addr_reg == LAST_ADDR) begin
            clr_addr_next = '0;
            state_next    = ST_START;
          end else begin
            clr_addr_next = clr_addr_reg + 1'b1;
          end
        end
        ST_START: begin
          render_start_next = 1'b1;
          state_next        = ST_RENDER;
        end
        ST_RENDER: begin
          // Registered pass-through; a write alongside r_done still lands
          // because the move to ST_WAIT only takes effect next cycle.
          fb_wr_en_next   = r_wr_en && addr_in_range;
          fb_wr_addr_next = r_wr_addr;
          fb_wr_data_next = r_wr_data;
          if (r_done) begin
            state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (vsync) begin
            fb_swap_next   = 1'b1;
            frame_cnt_next = frame_cnt_reg + 1'b1;
            state_next     = ST_CLEAR;
          end
        end
        default: state_next = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_CLEAR;
      clr_addr_reg     <= '0;
      render_start_reg <= 1'b0;
      fb_wr_en_reg     <= 1'b0;
      fb_wr_addr_reg   <= '0;
      fb_wr_data_reg   <= 1'b0;
      fb_swap_reg      <= 1'b0;
      frame_cnt_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      clr_addr_reg     <= clr_addr_next;
      render_start_reg <= render_start_next;
      fb_wr_en_reg     <= fb_wr_en_next;
      fb_wr_addr_reg   <= fb_wr_addr_next;
      fb_wr_data_reg   <= fb_wr_data_next;
      fb_swap_reg      <= fb_swap_next;
      frame_cnt_reg    <= frame_cnt_next;
    end
  end

  assign render_start = render_start_reg;
  assign fb_wr_en     = fb_wr_en_reg;
  assign fb_wr_addr   = fb_wr_addr_reg;
  assign fb_wr_data   = fb_wr_data_reg;
  assign fb_swap      = fb_swap_reg;
  assign frame_cnt    = frame_cnt_reg;

`ifdef FRAME_BUFFER_SEQUENCER_STATS_EN
  // Any vsync seen outside ST_WAIT cannot produce a swap. This includes the
  // r_done+vsync cycle in ST_RENDER, where the state is still ST_RENDER.
  logic             vsync_missed;
  logic [CNT_W-1:0] missed_reg;

  assign vsync_missed = ce && vsync && (state_reg != ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      missed_reg <= '0;
    end else if (vsync_missed && (missed_reg != '1)) begin
      missed_reg <= missed_reg + 1'b1;
    end
  end

  assign missed_vsync = missed_reg;
`else
  assign missed_vsync = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_sequencer.sv
module tb_frame_buffer_sequencer;

  localparam int ADDR_W = 19;
  localparam int CNT_W  = 16;
`ifdef FRAME_BUFFER_SEQUENCER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              ce;
  logic              vsync;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_data;
  logic              r_done;
  logic              render_start;
  logic              fb_wr_en;
  logic [ADDR_W-1:0] fb_wr_addr;
  logic              fb_wr_data;
  logic              fb_swap;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  missed_vsync;

  int checks   = 0;
  int failures = 0;

  frame_buffer_sequencer #(
    .ADDR_W     (ADDR_W),
    .PIXELS     (16),
    .CLEAR_VALUE(1'b0),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .vsync       (vsync),
    .r_wr_en     (r_wr_en),
    .r_wr_addr   (r_wr_addr),
    .r_wr_data   (r_wr_data),
    .r_done      (r_done),
    .render_start(render_start),
    .fb_wr_en    (fb_wr_en),
    .fb_wr_addr  (fb_wr_addr),
    .fb_wr_data  (fb_wr_data),
    .fb_swap     (fb_swap),
    .frame_cnt   (frame_cnt),
    .missed_vsync(missed_vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance through the remainder of a clear pass until render_start shows.
  task automatic finish_clear();
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (render_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL finish_clear: render_start seen=%0b required=1 within 40 cycles", seen);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b0; vsync = 1'b0; r_wr_en = 1'b0;
    r_wr_addr = '0; r_wr_data = 1'b0; r_done = 1'b0;
    repeat (3) tick();
    checks++;
    if ({render_start, fb_wr_en, fb_wr_addr, fb_wr_data, fb_swap, frame_cnt, missed_vsync} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rs=%0b en=%0b addr=%0d d=%0b sw=%0b fc=%0d mv=%0d required all 0",
               render_start, fb_wr_en, fb_wr_addr, fb_wr_data, fb_swap, frame_cnt, missed_vsync);
    end
    $display("[tb] reset checked");
  endtask

  task automatic test_clear();
    rst_n = 1'b1; ce = 1'b1;
    // Renderer writes during clear must be dropped.
    r_wr_en = 1'b1; r_wr_addr = 19'd9; r_wr_data = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({render_start, fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b0, 1'b1, 19'(i), 1'b0}) begin
        failures++;
        $display("FAIL clear_write_%0d: got rs=%0b en=%0b addr=%0d d=%0b required rs=0 en=1 addr=%0d d=0",
                 i, render_start, fb_wr_en, fb_wr_addr, fb_wr_data, i);
      end
    end
    r_wr_en = 1'b0;
    tick();
    checks++;
    if ({render_start, fb_wr_en} !== 2'b10) begin
      failures++;
      $display("FAIL clear_render_start: got rs=%0b en=%0b required rs=1 en=0", render_start, fb_wr_en);
    end
    $display("[tb] clear pass 0..15 then render_start checked");
  endtask

  task automatic test_render();
    r_wr_en = 1'b1; r_wr_addr = 19'd5; r_wr_data = 1'b1;
    tick();
    checks++;
    if ({render_start, fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b0, 1'b1, 19'd5, 1'b1}) begin
      failures++;
      $display("FAIL render_addr5: got rs=%0b en=%0b addr=%0d d=%0b required rs=0 en=1 addr=5 d=1",
               render_start, fb_wr_en, fb_wr_addr, fb_wr_data);
    end
    r_wr_addr = 19'd16;
    tick();
    checks++;
    if (fb_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL render_addr16_suppressed: got en=%0b required 0", fb_wr_en);
    end
    r_wr_addr = 19'd15; r_wr_data = 1'b0;
    tick();
    checks++;
    if ({fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b1, 19'd15, 1'b0}) begin
      failures++;
      $display("FAIL render_addr15: got en=%0b addr=%0d d=%0b required en=1 addr=15 d=0",
               fb_wr_en, fb_wr_addr, fb_wr_data);
    end
    r_wr_en = 1'b0;
    tick();
    checks++;
    if (fb_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL render_idle: got en=%0b required 0", fb_wr_en);
    end
    // A write in the same cycle as r_done is still forwarded.
    r_wr_en = 1'b1; r_wr_addr = 19'd3; r_wr_data = 1'b1; r_done = 1'b1;
    tick();
    checks++;
    if ({fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b1, 19'd3, 1'b1}) begin
      failures++;
      $display("FAIL render_done_write: got en=%0b addr=%0d d=%0b required en=1 addr=3 d=1",
               fb_wr_en, fb_wr_addr, fb_wr_data);
    end
    r_done = 1'b0; r_wr_addr = 19'd2;
    $display("[tb] render pass-through checked");
  endtask

  task automatic test_swap();
    // Waiting for vsync: renderer writes (r_wr_en still 1) are dropped.
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if ({fb_wr_en, fb_swap} !== 2'b00) begin
        failures++;
        $display("FAIL wait_idle_%0d: got en=%0b sw=%0b required en=0 sw=0", k, fb_wr_en, fb_swap);
      end
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL frame_cnt_before_swap: got %0d required 0", frame_cnt);
    end
    r_wr_en = 1'b0; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++;
    if ({fb_swap, fb_wr_en, frame_cnt} !== {1'b1, 1'b0, 16'd1}) begin
      failures++;
      $display("FAIL swap_pulse: got sw=%0b en=%0b fc=%0d required sw=1 en=0 fc=1", fb_swap, fb_wr_en, frame_cnt);
    end
    tick();
    checks++;
    if ({fb_swap, fb_wr_en, fb_wr_addr} !== {1'b0, 1'b1, 19'd0}) begin
      failures++;
      $display("FAIL swap_reclear: got sw=%0b en=%0b addr=%0d required sw=0 en=1 addr=0", fb_swap, fb_wr_en, fb_wr_addr);
    end
    finish_clear();
    // Wrap: preload the swap counter with all-ones while waiting for vsync.
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    force dut.frame_cnt_reg = 16'hFFFF;
    tick();
    release dut.frame_cnt_reg;
    #1;
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL frame_cnt_preload: got %h required ffff", frame_cnt);
    end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++;
    if ({fb_swap, frame_cnt} !== {1'b1, 16'd0}) begin
      failures++;
      $display("FAIL frame_cnt_wrap: got sw=%0b fc=%h required sw=1 fc=0000", fb_swap, frame_cnt);
    end
    $display("[tb] swap and frame_cnt wrap checked");
  endtask

  task automatic test_missed();
    finish_clear();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++;
    if ({fb_swap, missed_vsync} !== {1'b0, 16'(STATS)}) begin
      failures++;
      $display("FAIL missed_render_vsync: got sw=%0b mv=%0d required sw=0 mv=%0d", fb_swap, missed_vsync, STATS);
    end
    tick();
    r_done = 1'b1; vsync = 1'b1;
    tick();
    r_done = 1'b0; vsync = 1'b0;
    checks++;
    if (fb_swap !== 1'b0) begin
      failures++;
      $display("FAIL missed_done_vsync: got sw=%0b required 0", fb_swap);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (fb_swap !== 1'b0) begin
        failures++;
        $display("FAIL missed_wait_%0d: got sw=%0b required 0", k, fb_swap);
      end
    end
    checks++;
    if (missed_vsync !== 16'(2 * STATS)) begin
      failures++;
      $display("FAIL missed_count: got %0d required %0d", missed_vsync, 2 * STATS);
    end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++;
    if ({fb_swap, frame_cnt} !== {1'b1, 16'd1}) begin
      failures++;
      $display("FAIL missed_next_vsync_swap: got sw=%0b fc=%0d required sw=1 fc=1", fb_swap, frame_cnt);
    end
    $display("[tb] missed vsync handling checked");
  endtask

  task automatic test_ce();
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({fb_wr_en, fb_wr_addr} !== {1'b1, 19'(i)}) begin
        failures++;
        $display("FAIL ce_pre_%0d: got en=%0b addr=%0d required en=1 addr=%0d", i, fb_wr_en, fb_wr_addr, i);
      end
    end
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vsync = (k == 1);
      tick();
      checks++;
      if ({fb_wr_en, fb_swap} !== 2'b00) begin
        failures++;
        $display("FAIL ce_hold_%0d: got en=%0b sw=%0b required en=0 sw=0", k, fb_wr_en, fb_swap);
      end
    end
    vsync = 1'b0; ce = 1'b1;
    tick();
    checks++;
    if ({fb_wr_en, fb_wr_addr} !== {1'b1, 19'd7}) begin
      failures++;
      $display("FAIL ce_resume_7: got en=%0b addr=%0d required en=1 addr=7", fb_wr_en, fb_wr_addr);
    end
    tick();
    checks++;
    if ({fb_wr_en, fb_wr_addr} !== {1'b1, 19'd8}) begin
      failures++;
      $display("FAIL ce_resume_8: got en=%0b addr=%0d required en=1 addr=8", fb_wr_en, fb_wr_addr);
    end
    checks++;
    if ({frame_cnt, missed_vsync} !== {16'd1, 16'(2 * STATS)}) begin
      failures++;
      $display("FAIL ce_vsync_ignored: got fc=%0d mv=%0d required fc=1 mv=%0d", frame_cnt, missed_vsync, 2 * STATS);
    end
    repeat (7) tick();
    // render_start is due now; ce=0 must defer it by one enabled cycle.
    ce = 1'b0;
    tick();
    checks++;
    if ({render_start, fb_wr_en} !== 2'b00) begin
      failures++;
      $display("FAIL ce_defer_start: got rs=%0b en=%0b required rs=0 en=0", render_start, fb_wr_en);
    end
    ce = 1'b1;
    tick();
    checks++;
    if (render_start !== 1'b1) begin
      failures++;
      $display("FAIL ce_pending_start: got rs=%0b required 1", render_start);
    end
    $display("[tb] clock enable hold checked");
  endtask

  task automatic test_async_reset();
    r_wr_en = 1'b1; r_wr_addr = 19'd4; r_wr_data = 1'b1;
    tick();
    r_wr_en = 1'b0;
    checks++;
    if ({fb_wr_en, fb_wr_addr} !== {1'b1, 19'd4}) begin
      failures++;
      $display("FAIL areset_pre_write: got en=%0b addr=%0d required en=1 addr=4", fb_wr_en, fb_wr_addr);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({render_start, fb_wr_en, fb_wr_addr, fb_wr_data, fb_swap, frame_cnt, missed_vsync} !== '0) begin
      failures++;
      $display("FAIL areset_outputs: got rs=%0b en=%0b addr=%0d d=%0b sw=%0b fc=%0d mv=%0d required all 0",
               render_start, fb_wr_en, fb_wr_addr, fb_wr_data, fb_swap, frame_cnt, missed_vsync);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({fb_wr_en, fb_wr_addr, frame_cnt, missed_vsync} !== {1'b1, 19'd0, 16'd0, 16'd0}) begin
      failures++;
      $display("FAIL areset_restart: got en=%0b addr=%0d fc=%0d mv=%0d required en=1 addr=0 fc=0 mv=0",
               fb_wr_en, fb_wr_addr, frame_cnt, missed_vsync);
    end
    tick();
    checks++;
    if ({fb_wr_en, fb_wr_addr} !== {1'b1, 19'd1}) begin
      failures++;
      $display("FAIL areset_restart_1: got en=%0b addr=%0d required en=1 addr=1", fb_wr_en, fb_wr_addr);
    end
    $display("[tb] asynchronous reset checked");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_render();
    test_swap();
    test_missed();
    test_ce();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
